hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard unit for the five-stage core (F=0, D=1, E=2, M=3, W=4). It consumes the per-instruction control fields produced by the command decoder in D: operand use times, result-ready stage, destination type and multiply/divide class. It keeps its own shadow records of the instructions in E, M and W. From those records it drives the D-stage stall, the forwarding selects for D, E and M, and the HI/LO multiply/divide busy interlock.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `d_rs`, `d_rt`, `d_rd`  in  5 each  register fields of the instruction in D.
- `d_rs_use`, `d_rt_use`  in  4 each  Tuse: 0 = needed in D, 1 = needed in E, 4 = not used.
- `d_dst_type`  in  4  destination: 0 = rd, 1 = rt, 2 = $31, 3 = none.
- `d_dst_save`  in  4  stage whose input register first holds the result (1–4). Only bits [2:0] are used.
- `d_ALUop`  in  4  3/8 = mult/multu; 4/9 = div/divu; 10/11 = mthi/mtlo.
- `d_GRF_write`  in  4  4/5 = mfhi/mflo.
- `flush`  in  1  exception/eret flush; kills the E and M records.
- `stall`  out  1  hold F/D and insert a bubble into E.
- `fwd_d_rs`, `fwd_d_rt`  out  2 each  0 = GRF, 1 = E, 2 = M, 3 = W.
- `fwd_e_rs`, `fwd_e_rt`  out  2 each  0 = latched value, 2 = M, 3 = W.
- `fwd_m_rt`  out  1  store data: 0 = latched value, 1 = W.
- `md_busy`  out  1  multiply/divide unit busy.

## Operation
- **Record format.** Each record holds {rs, rt, dst[4:0], ready[2:0]}. A bubble record is all zeros.
- **Destination.** dst comes from `d_dst_type`: 0 → rd, 1 → rt, 2 → 31, 3 → 0. dst = 0 means the record never matches.
- **Advance.** Every cycle: W ← M, M ← E.
  - E ← D record if not stalled.
  - E ← bubble if `stall` or `flush`.
  - M ← bubble if `flush`.
  - W always advances normally.
  - `flush` has priority over `stall`.
- **Remaining time.** For a record in stage s, Tnew = max(ready − s, 0).
- **Stall condition.** The D instruction stalls if, for rs or rt with Tuse ≠ 4 and address ≠ 0, the nearest matching record (priority E > M > W) has Tnew > Tuse.
  - Only the nearest match counts. Older matches are never used.
- **D forwarding.** For each of rs and rt, take the nearest matching record with Tnew = 0 at its stage:
  - E → 1, M → 2, W → 3.
  - If there is no match, or the nearest match still has Tnew > 0 → 0.
- **E forwarding.** Uses the E record's rs/rt against the M then W records. The nearest match with ready ≤ its stage selects 2 (M) or 3 (W); otherwise 0.
- **M forwarding.** `fwd_m_rt` = 1 iff the W record's dst equals the M record's rt, and that rt ≠ 0.
- **Multiply/divide counter.** 4-bit `md_cnt`.
  - Loaded with 5 when a mult/multu enters E.
  - Loaded with 10 when a div/divu enters E.
  - Otherwise decrements while nonzero.
  - `md_busy` = (`md_cnt` ≠ 0).
- **Multiply/divide interlock.** A D instruction of md class (mult, multu, div, divu, mthi, mtlo, mfhi, mflo) stalls while `md_busy`.
- **Flush and the counter.** `flush` does not change `md_cnt`. Cancelling an in-flight operation belongs to the multiply/divide unit.
- **Combinational outputs.** `stall` and all fwd selects are combinational from the records and the D inputs. The records and `md_cnt` are registered.

## Timing
- **Reset.** While `reset` is high, all records and `md_cnt` are 0. This forces `stall` = 0, `md_busy` = 0 and every fwd output = 0 (no records match).
- **Reset release.** Normal operation starts at the first rising edge after `reset` is released.
- **Load-use.** 1 stall cycle for a consumer in E. 2 stall cycles for a consumer in D (branch or jr).
- **ALU result (ready = 3).** 0 stall cycles for a consumer in E. 1 stall cycle for a consumer in D.
- **jal / lui (ready = 1).** Never stall a consumer; `fwd_d` = 1 on the cycle after issue.
- **Multiply/divide.** A mult makes `md_busy` high for exactly 5 cycles, counting from the cycle it sits in E; a div for exactly 10.
  - A D-stage md instruction issues on the first cycle `md_busy` = 0.
- **Combined stall.** A cycle with both a data hazard and an md hazard is a single stall.
- **Reset mid-stall.** Records clear at once and `stall` drops in the same cycle.

## Test plan
1. lw $1 then add $2,$1,$3 → `stall` = 1 for one cycle. Next cycle `stall` = 0 and `fwd_d_rs` = 0; when the add is in E, `fwd_e_rs` = 3.
2. add $1,… then beq $1,$2 → `stall` = 1 for one cycle, then `fwd_d_rs` = 2.
3. jal then jr $31 → `stall` = 0 and `fwd_d_rs` = 1 while the jal is in E.
4. mult then mflo → `md_busy` high for 5 cycles and `stall` high for 5 cycles. Repeat with div → 10 cycles each.
5. lw $0 then add using $0 → `stall` = 0 and all fwd = 0. lw $1, add $1,…, then a consumer of $1 → the nearest (add) record wins.
6. `flush` during a load-use stall → `stall` = 0 next cycle, and E and M hold bubbles. Assert `reset` mid-divide → `md_busy` = 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard unit for the five-stage core (F=0, D=1, E=2, M=3, W=4).
// Keeps shadow records {rs, rt, dst, ready} for E, M and W. From them it
// derives the D-stage stall, the D/E/M forwarding selects and the
// multiply/divide busy interlock. The stall and the selects are
// combinational. The records and the busy counter are registered.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  input  logic [3:0] d_rs_use,
  input  logic [3:0] d_rt_use,
  input  logic [3:0] d_dst_type,
  input  logic [3:0] d_dst_save,
  input  logic [3:0] d_ALUop,
  input  logic [3:0] d_GRF_write,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt,
  output logic       md_busy
);

  // Shadow record of one in-flight instruction. ready is the stage whose
  // input register first holds the result.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [2:0] ready;
  } rec_t;

  // Result of looking up a D operand among the E/M/W records.
  typedef struct packed {
    logic       hit;
    logic [1:0] src;
    logic [2:0] tnew;
  } look_t;

  localparam rec_t       BUBBLE         = 18'd0;
  localparam logic [2:0] STAGE_E        = 3'd2;
  localparam logic [2:0] STAGE_M        = 3'd3;
  localparam logic [2:0] STAGE_W        = 3'd4;
  localparam logic [3:0] TUSE_NONE      = 4'd4;
  localparam logic [1:0] FWD_HOLD       = 2'd0;
  localparam logic [1:0] FWD_E          = 2'd1;
  localparam logic [1:0] FWD_M          = 2'd2;
  localparam logic [1:0] FWD_W          = 2'd3;
  localparam logic [3:0] MD_MULT_CYCLES = 4'd5;
  localparam logic [3:0] MD_DIV_CYCLES  = 4'd10;

  rec_t       e_rec;
  rec_t       m_rec;
  rec_t       w_rec;
  rec_t       e_next;
  rec_t       m_next;
  rec_t       d_rec;
  logic [4:0] d_dst;
  logic [3:0] md_cnt;
  logic [3:0] md_cnt_next;
  logic       d_is_mult;
  logic       d_is_div;
  logic       d_is_mdmove;
  logic       d_is_mfhilo;
  logic       d_md_class;
  look_t      look_rs;
  look_t      look_rt;
  logic       data_stall;
  logic       md_stall;
  logic       md_issue;
  logic       unused_bits;

  // Cycles still needed before a record's result reaches its current stage's input.
  function automatic logic [2:0] tnew_of(input rec_t r, input logic [2:0] stage);
    logic [2:0] t;
    if (r.ready > stage) begin
      t = r.ready - stage;
    end else begin
      t = 3'd0;
    end
    return t;
  endfunction

  // A record matches only a nonzero destination equal to the operand address.
  function automatic logic hits(input rec_t r, input logic [4:0] addr);
    return (r.dst != 5'd0) && (r.dst == addr);
  endfunction

  // Nearest producer of a D operand, E before M before W.
  function automatic look_t look_d(input logic [4:0] addr, input rec_t e,
                                   input rec_t m, input rec_t w);
    look_t l;
    l = 6'd0;
    if (hits(e, addr)) begin
      l.hit  = 1'b1;
      l.src  = FWD_E;
      l.tnew = tnew_of(e, STAGE_E);
    end else if (hits(m, addr)) begin
      l.hit  = 1'b1;
      l.src  = FWD_M;
      l.tnew = tnew_of(m, STAGE_M);
    end else if (hits(w, addr)) begin
      l.hit  = 1'b1;
      l.src  = FWD_W;
      l.tnew = tnew_of(w, STAGE_W);
    end else begin
      l = 6'd0;
    end
    return l;
  endfunction

  // An operand stalls when its nearest producer cannot deliver in time.
  function automatic logic operand_stall(input logic [4:0] addr, input logic [3:0] tuse,
                                         input look_t l);
    logic s;
    if ((tuse != TUSE_NONE) && (addr != 5'd0) && l.hit) begin
      s = ({1'b0, l.tnew} > tuse);
    end else begin
      s = 1'b0;
    end
    return s;
  endfunction

  // D select: the nearest producer only, and only once its value exists.
  function automatic logic [1:0] d_select(input look_t l);
    logic [1:0] sel;
    if (l.hit && (l.tnew == 3'd0)) begin
      sel = l.src;
    end else begin
      sel = FWD_HOLD;
    end
    return sel;
  endfunction

  // E select: nearest of M then W, provided that record's result is ready.
  function automatic logic [1:0] e_select(input logic [4:0] addr, input rec_t m, input rec_t w);
    logic [1:0] sel;
    if (hits(m, addr)) begin
      if (m.ready <= STAGE_M) begin
        sel = FWD_M;
      end else begin
        sel = FWD_HOLD;
      end
    end else if (hits(w, addr)) begin
      if (w.ready <= STAGE_W) begin
        sel = FWD_W;
      end else begin
        sel = FWD_HOLD;
      end
    end else begin
      sel = FWD_HOLD;
    end
    return sel;
  endfunction

  // Build the record the D instruction would carry into E.
  always_comb begin
    d_dst = 5'd0;
    case (d_dst_type)
      4'd0:    d_dst = d_rd;
      4'd1:    d_dst = d_rt;
      4'd2:    d_dst = 5'd31;
      default: d_dst = 5'd0;
    endcase
    d_rec       = BUBBLE;
    d_rec.rs    = d_rs;
    d_rec.rt    = d_rt;
    d_rec.dst   = d_dst;
    d_rec.ready = d_dst_save[2:0];
  end

  // Classify the D instruction for the multiply/divide interlock.
  always_comb begin
    d_is_mult   = 1'b0;
    d_is_div    = 1'b0;
    d_is_mdmove = 1'b0;
    d_is_mfhilo = 1'b0;
    case (d_ALUop)
      4'd3, 4'd8:   d_is_mult   = 1'b1;
      4'd4, 4'd9:   d_is_div    = 1'b1;
      4'd10, 4'd11: d_is_mdmove = 1'b1;
      default:      d_is_mult   = 1'b0;
    endcase
    case (d_GRF_write)
      4'd4, 4'd5: d_is_mfhilo = 1'b1;
      default:    d_is_mfhilo = 1'b0;
    endcase
    d_md_class = d_is_mult | d_is_div | d_is_mdmove | d_is_mfhilo;
  end

  // Data and md hazards merge into one stall; selects follow nearest producers.
  always_comb begin
    look_rs    = look_d(d_rs, e_rec, m_rec, w_rec);
    look_rt    = look_d(d_rt, e_rec, m_rec, w_rec);
    data_stall = operand_stall(d_rs, d_rs_use, look_rs) |
                 operand_stall(d_rt, d_rt_use, look_rt);
    md_stall   = d_md_class & md_busy;
    stall      = data_stall | md_stall;
    fwd_d_rs   = d_select(look_rs);
    fwd_d_rt   = d_select(look_rt);
    fwd_e_rs   = e_select(e_rec.rs, m_rec, w_rec);
    fwd_e_rt   = e_select(e_rec.rt, m_rec, w_rec);
    if ((m_rec.rt != 5'd0) && (w_rec.dst == m_rec.rt)) begin
      fwd_m_rt = 1'b1;
    end else begin
      fwd_m_rt = 1'b0;
    end
  end

  // Next E/M records: flush kills both, a stall only bubbles E.
  always_comb begin
    if (flush || stall) begin
      e_next = BUBBLE;
    end else begin
      e_next = d_rec;
    end
    if (flush) begin
      m_next = BUBBLE;
    end else begin
      m_next = e_rec;
    end
  end

  // Busy counter loads when a mult/div actually enters E, otherwise runs down.
  always_comb begin
    md_issue = ~stall & ~flush;
    if (md_issue && d_is_mult) begin
      md_cnt_next = MD_MULT_CYCLES;
    end else if (md_issue && d_is_div) begin
      md_cnt_next = MD_DIV_CYCLES;
    end else if (md_cnt != 4'd0) begin
      md_cnt_next = md_cnt - 4'd1;
    end else begin
      md_cnt_next = md_cnt;
    end
  end

  // Shadow pipeline and busy counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rec  <= BUBBLE;
      m_rec  <= BUBBLE;
      w_rec  <= BUBBLE;
      md_cnt <= 4'd0;
    end else begin
      e_rec  <= e_next;
      m_rec  <= m_next;
      w_rec  <= m_rec;
      md_cnt <= md_cnt_next;
    end
  end

  assign md_busy = (md_cnt != 4'd0);

  // Record fields that no rule reads, gathered so they are visibly intentional.
  assign unused_bits = ^{d_dst_save[3], m_rec.rs, w_rec.rs, w_rec.rt};

endmodule
